// File: rtl/jpeg_enc_pkg.sv
// Shared types for the JPEG stream packer: FSM state encoding, word width
// and the layout of one output FIFO entry.
package jpeg_enc_pkg;

   localparam int WORD_W  = 32;
   localparam int ENTRY_W = WORD_W + 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PACK  = 2'd1,
      S_FLUSH = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   typedef struct packed {
      logic              last;
      logic [2:0]        bytes;
      logic [WORD_W-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/jpeg_stream_packer_if.sv
// Word-output bus of the packer: valid/ready handshake plus word qualifiers.
interface jpeg_stream_packer_if;
   import jpeg_enc_pkg::*;

   logic [WORD_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic              wr_last;
   logic [2:0]        wr_bytes;

   modport master (output wr_data, wr_valid, wr_last, wr_bytes, input wr_ready);
   modport slave  (input wr_data, wr_valid, wr_last, wr_bytes, output wr_ready);

endinterface

// File: rtl/jpeg_sync_fifo.sv
// Synchronous FIFO with full/empty flags. Read data is presented directly
// from the head entry (zero while empty); a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module jpeg_sync_fifo
   import jpeg_enc_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = ENTRY_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values from accepted pushes and pops.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/jpeg_stream_packer.sv
// Packs the encoder byte stream into little-endian 32-bit words, buffers them
// in an output FIFO and marks the final word of each image. Bytes have no
// backpressure, so anything that cannot be stored is dropped and flagged.
module jpeg_stream_packer
   import jpeg_enc_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 22
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [7:0]           img_data,
   input  logic                 img_valid,
   input  logic                 img_done,
   jpeg_stream_packer_if.master wr,
   output logic [CNT_W-1:0]     total_bytes,
   output logic                 stream_done,
   output logic                 overflow
);

   state_e            state_q, state_d;
   logic [WORD_W-1:0] pack_data_q, pack_data_d;
   logic [2:0]        pack_cnt_q, pack_cnt_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic              overflow_q, overflow_d;
   logic              done_q, done_d;

   logic              fifo_push;
   fifo_entry_t       push_entry;
   fifo_entry_t       pop_entry;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   jpeg_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .pop_data  (pop_entry),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign wr.wr_valid  = !fifo_empty;
   assign wr.wr_data   = pop_entry.data;
   assign wr.wr_last   = pop_entry.last;
   assign wr.wr_bytes  = pop_entry.bytes;
   assign fifo_pop     = wr.wr_valid && wr.wr_ready;
   assign total_bytes  = total_q;
   assign stream_done  = done_q;
   assign overflow     = overflow_q;

   // Next-state, packing and FIFO-push decisions.
   always_comb begin
      state_d     = state_q;
      pack_data_d = pack_data_q;
      pack_cnt_d  = pack_cnt_q;
      total_d     = total_q;
      overflow_d  = overflow_q;
      done_d      = 1'b0;
      fifo_push   = 1'b0;
      push_entry  = '0;

      case (state_q)
         S_IDLE: begin
            if (img_valid) begin
               total_d     = {{(CNT_W-1){1'b0}}, 1'b1};
               pack_data_d = {24'b0, img_data};
               pack_cnt_d  = 3'd1;
               state_d     = img_done ? S_FLUSH : S_PACK;
            end else if (img_done) begin
               done_d = 1'b1;
            end
         end

         S_PACK: begin
            if (img_valid) begin
               total_d = sat_inc(total_q);
               if (pack_cnt_q == 3'd4) begin
                  fifo_push        = 1'b1;
                  push_entry.last  = 1'b0;
                  push_entry.bytes = 3'd4;
                  push_entry.data  = pack_data_q;
                  if (fifo_full && !fifo_pop) overflow_d = 1'b1;
                  pack_data_d = {24'b0, img_data};
                  pack_cnt_d  = 3'd1;
               end else begin
                  pack_data_d[{pack_cnt_q[1:0], 3'b000} +: 8] = img_data;
                  pack_cnt_d = pack_cnt_q + 3'd1;
               end
            end
            if (img_done) state_d = S_FLUSH;
         end

         S_FLUSH: begin
            if (img_valid) overflow_d = 1'b1;
            if (!fifo_full || fifo_pop) begin
               fifo_push        = 1'b1;
               push_entry.last  = 1'b1;
               push_entry.bytes = pack_cnt_q;
               push_entry.data  = pack_data_q;
               pack_data_d      = '0;
               pack_cnt_d       = 3'd0;
               state_d          = S_DRAIN;
            end
         end

         S_DRAIN: begin
            if (img_valid) overflow_d = 1'b1;
            if (fifo_pop && pop_entry.last) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State, pack register, counters and status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         pack_data_q <= '0;
         pack_cnt_q  <= 3'd0;
         total_q     <= '0;
         overflow_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pack_data_q <= pack_data_d;
         pack_cnt_q  <= pack_cnt_d;
         total_q     <= total_d;
         overflow_q  <= overflow_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_jpeg_stream_packer.sv
// Scoreboard bench for jpeg_stream_packer: stimulus pushes expected words,
// a negedge monitor pops and compares every transferred word.
module tb_jpeg_stream_packer;
   import jpeg_enc_pkg::*;

   localparam int DEPTH = 16;
   localparam int CW    = 22;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [7:0]    img_data;
   logic          img_valid;
   logic          img_done;
   logic [CW-1:0] total_bytes;
   logic          stream_done;
   logic          overflow;

   jpeg_stream_packer_if wr_bus ();

   jpeg_stream_packer #(
      .FIFO_DEPTH (DEPTH),
      .CNT_W      (CW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .img_data    (img_data),
      .img_valid   (img_valid),
      .img_done    (img_done),
      .wr          (wr_bus),
      .total_bytes (total_bytes),
      .stream_done (stream_done),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   logic [35:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          sd_count = 0;
   bit          rand_rdy = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: counts stream_done pulses and scores every transferred word.
   initial begin
      logic [35:0] got;
      logic [35:0] e;
      forever begin
         @(negedge clk);
         if (stream_done === 1'b1) sd_count++;
         if (wr_bus.wr_valid === 1'b1 && wr_bus.wr_ready === 1'b1) begin
            got = {wr_bus.wr_last, wr_bus.wr_bytes, wr_bus.wr_data};
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_word: got 0x%0h expected none", got);
            end else begin
               e = exp_q.pop_front();
               check("word", {28'b0, got}, {28'b0, e});
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      if (rand_rdy) wr_bus.wr_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      img_valid = 1'b1;
      img_data  = b;
      cyc();
      img_valid = 1'b0;
   endtask

   task automatic pulse_done();
      img_done = 1'b1;
      cyc();
      img_done = 1'b0;
   endtask

   task automatic exp_word(input logic last, input logic [2:0] nb, input logic [31:0] d);
      exp_q.push_back({last, nb, d});
   endtask

   task automatic wait_done(input int start, input string name);
      int k = 0;
      while (sd_count == start && k < 3000) begin
         cyc();
         k++;
      end
      check(name, sd_count, start + 1);
      repeat (4) cyc();
      check({name, "_once"}, sd_count, start + 1);
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      int          s;
      logic [31:0] w;
      logic [7:0]  b;

      reset_n           = 1'b0;
      img_data          = 8'h00;
      img_valid         = 1'b0;
      img_done          = 1'b0;
      wr_bus.wr_ready   = 1'b0;
      repeat (3) cyc();
      check("rst_outputs",
            {wr_bus.wr_data, wr_bus.wr_valid, wr_bus.wr_last, wr_bus.wr_bytes, stream_done, overflow},
            64'h0);
      check("rst_total", total_bytes, 0);
      reset_n = 1'b1;
      cyc();

      // 8 bytes, two full words
      wr_bus.wr_ready = 1'b1;
      s = sd_count;
      exp_word(1'b0, 3'd4, 32'h04030201);
      exp_word(1'b1, 3'd4, 32'h08070605);
      for (int i = 1; i <= 8; i++) send_byte(i[7:0]);
      pulse_done();
      wait_done(s, "img8_done");
      check("img8_total", total_bytes, 8);

      // 5 bytes, last word partial
      s = sd_count;
      exp_word(1'b0, 3'd4, 32'hADACABAA);
      exp_word(1'b1, 3'd1, 32'h000000AE);
      for (int i = 0; i < 5; i++) send_byte(8'hAA + i[7:0]);
      pulse_done();
      wait_done(s, "img5_done");
      check("img5_total", total_bytes, 5);

      // img_done while idle
      s = sd_count;
      pulse_done();
      check("idle_done_pulse", stream_done, 1'b1);
      cyc();
      check("idle_done_low", stream_done, 1'b0);
      repeat (3) cyc();
      check("idle_done_count", sd_count, s + 1);
      check("idle_no_valid", wr_bus.wr_valid, 1'b0);
      check("idle_no_ovf", overflow, 1'b0);

      // Overflow with the sink stalled: word 16 is dropped, word 17 is last
      wr_bus.wr_ready = 1'b0;
      s = sd_count;
      w = '0;
      for (int i = 0; i < 4 * (DEPTH + 2); i++) begin
         w[8 * (i % 4) +: 8] = i[7:0];
         if (i % 4 == 3 && i / 4 != DEPTH) exp_word(i / 4 == DEPTH + 1, 3'd4, w);
      end
      for (int i = 0; i < 4 * (DEPTH + 2); i++) send_byte(i[7:0]);
      check("ovf_set", overflow, 1'b1);
      check("ovf_fifo_full_valid", wr_bus.wr_valid, 1'b1);
      pulse_done();
      repeat (3) cyc();
      wr_bus.wr_ready = 1'b1;
      wait_done(s, "ovf_done");
      check("ovf_sticky", overflow, 1'b1);

      // Reset mid-image discards everything
      wr_bus.wr_ready = 1'b0;
      for (int i = 0; i < 6; i++) send_byte(8'h60 + i[7:0]);
      s = sd_count;
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_outputs",
            {wr_bus.wr_data, wr_bus.wr_valid, wr_bus.wr_last, wr_bus.wr_bytes, stream_done, overflow},
            64'h0);
      check("midrst_total", total_bytes, 0);
      cyc();
      cyc();
      reset_n = 1'b1;
      cyc();
      check("midrst_no_done", sd_count, s);
      wr_bus.wr_ready = 1'b1;
      exp_word(1'b1, 3'd3, 32'h00332211);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      pulse_done();
      wait_done(s, "img3_done");
      check("img3_total", total_bytes, 3);

      // 1000-byte image with random sink readiness
      s = sd_count;
      w = '0;
      for (int i = 0; i < 1000; i++) begin
         b = 8'(i * 7 + 3);
         w[8 * (i % 4) +: 8] = b;
         if (i % 4 == 3) exp_word(i == 999, 3'd4, w);
      end
      check("long_word_count", exp_q.size(), 250);
      rand_rdy = 1'b1;
      for (int i = 0; i < 1000; i++) send_byte(8'(i * 7 + 3));
      pulse_done();
      wait_done(s, "long_done");
      rand_rdy = 1'b0;
      wr_bus.wr_ready = 1'b1;
      check("long_total", total_bytes, 1000);
      check("long_no_ovf", overflow, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/jpeg_stream_packer.md
JPEG_STREAM_PACKER -- requirements
Module: jpeg_stream_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning output FIFO depth in 32-bit entries (power of two, >=4).
REQ-002 SHALL have parameter CNT_W, default 22, meaning width of the stream byte counter.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port img_data  input  8  encoder output byte, qualified by img_valid.
REQ-006 SHALL have port img_valid  input  1  one byte per asserted cycle; no backpressure to the encoder.
REQ-007 SHALL have port img_done  input  1  single-cycle end-of-image pulse.
REQ-008 SHALL have port wr_data  output  32  packed word; first stream byte in [7:0].
REQ-009 SHALL have port wr_valid  output  1  wr_data, wr_last and wr_bytes are valid.
REQ-010 SHALL have port wr_ready  input  1  sink accepts the word.
REQ-011 SHALL have port wr_last  output  1  final word of the image.
REQ-012 SHALL have port wr_bytes  output  3  valid byte count in the word, 1..4.
REQ-013 SHALL have port total_bytes  output  CNT_W  bytes accepted in the current or last image.
REQ-014 SHALL have port stream_done  output  1  one-cycle pulse when the last word has been transferred.
REQ-015 SHALL have port overflow  output  1  sticky; a word or byte was dropped.

Function
REQ-016 SHALL implement states IDLE, PACK, FLUSH and DRAIN.
REQ-017 SHALL, in IDLE on img_valid, clear total_bytes, load the byte into lane 0 and enter PACK.
REQ-018 SHALL, in IDLE on img_done without img_valid, pulse stream_done on the next cycle, push no word and stay in IDLE.
REQ-019 SHALL pack bytes into lanes 0..3 in arrival order and hold a full word in the pack register until the next byte or img_done arrives.
REQ-020 SHALL push the held full word to the FIFO (wr_last=0, wr_bytes=4) in the cycle a fifth byte arrives; that byte goes to lane 0.
REQ-021 SHALL enter FLUSH on img_done in PACK; a byte coincident with img_done is packed first.
REQ-022 SHALL, in FLUSH, push the held word (wr_last=1, wr_bytes=1..4, unused lanes zero) once the FIFO is not full, then enter DRAIN.
REQ-023 SHALL, in DRAIN, pulse stream_done for one cycle in the cycle after the wr_last word is transferred, then return to IDLE.
REQ-024 SHALL transfer a word only when wr_valid and wr_ready are both high; wr_valid SHALL be high whenever the FIFO is not empty.
REQ-025 SHALL hold wr_data, wr_last and wr_bytes stable while wr_valid is high and wr_ready is low.
REQ-026 SHALL, when a PACK-state push finds the FIFO full, drop the word and set overflow.
REQ-027 SHALL drop img_valid bytes in FLUSH or DRAIN, set overflow, and ignore img_done there.
REQ-028 SHALL allow a FIFO push and pop in the same cycle when full, with no loss.
REQ-029 SHALL increment total_bytes per accepted byte, saturating at 2^CNT_W-1.
REQ-030 SHALL have a one-cycle latency from FIFO push to wr_valid.

Reset
REQ-031 SHALL, on reset_n low, immediately enter IDLE, empty the FIFO, clear the pack register, and drive wr_data=0, wr_valid=0, wr_last=0, wr_bytes=0, total_bytes=0, stream_done=0 and overflow=0.
REQ-032 SHALL, on reset mid-image, discard all buffered data, with no stream_done pulse.
REQ-033 SHALL clear overflow only by reset.

Structure
REQ-034 SHALL place the state encoding, WORD_W=32 and the FIFO entry layout {last, bytes[2:0], data[31:0]} in shared package jpeg_enc_pkg.
REQ-035 SHALL use one sub-module, jpeg_sync_fifo, as a 36-bit synchronous FIFO with full and empty flags.

Verification
REQ-036 SHALL verify: 8 bytes 0x01..0x08, then img_done, with wr_ready=1 -> words 0x04030201 (last=0, bytes=4) and 0x08070605 (last=1, bytes=4); stream_done; total_bytes=8.
REQ-037 SHALL verify: 5 bytes 0xAA..0xAE, then done -> 0xADACABAA (bytes=4) and 0x000000AE (last=1, bytes=1).
REQ-038 SHALL verify: wr_ready=0 and 4*(FIFO_DEPTH+2) bytes -> overflow=1; the first FIFO_DEPTH words are intact when wr_ready rises.
REQ-039 SHALL verify: img_done in IDLE -> no wr_valid; stream_done one cycle later; overflow=0.
REQ-040 SHALL verify: reset_n low after 6 bytes -> all outputs 0 immediately; a new 3-byte image yields a single word (last=1, bytes=3) and total_bytes=3.
REQ-041 SHALL verify: random wr_ready toggling over a 1000-byte image -> byte-exact reassembly, 250 words, stream_done exactly once.
